seq_pattern_counter: RTL and testbench



---
 rtl/seq_pkg.sv | 16 +
 rtl/sat_counter.sv | 39 +++
 rtl/seq_pattern_counter.sv | 187 ++++++++++++++++++
 tb/tb_seq_pattern_counter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared constants and FSM state encoding for the serial pattern detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_pkg;

  localparam int PAT_MAX_DEF = 16;  // default maximum pattern length in bits
  localparam int CNT_W_DEF   = 8;   // default match counter width

  // Encoding is visible on the debug state port, so values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with sticky saturation flag and synchronous clear.
// Latency: count/sat update on the clock edge after inc/clear; clear beats inc.
// Backpressure: none; inc requests above all-ones are dropped silently.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   inc          : add one this cycle (ignored once saturated)
//   clear        : zero count and sat next cycle
//   count        : current count
//   sat          : high once count has reached all-ones, until clear/reset
module sat_counter
  import seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
      // Flag goes up together with the increment that lands on all-ones.
      if (count == CNT_MAX - CNT_W'(1)) begin
        sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_pattern_counter.sv
// seq_pattern_counter: programmable serial bit-pattern detector with saturating match counter.
// Latency: match pulses (and count increments) the cycle after the completing bit is accepted.
// Backpressure: none on the bit stream; config is accepted only in IDLE with en low (cfg_ready).
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   en                   : detector enable; low returns to IDLE and drops partial history
//   cfg_valid/cfg_ready  : config handshake; cfg_pattern/cfg_len/cfg_overlap captured on both high
//   cfg_pattern          : bit [len-1] is the first bit received, bit 0 the last
//   cfg_len              : pattern length, clamped to [1, PAT_MAX] on load
//   cfg_overlap          : 1 = overlapping matches, 0 = restart with fresh bits after a match
//   cfg_mask             : (SEQDET_MASK_EN only) 1 = don't-care bit in the compare
//   bit_valid, bit_in    : serial input bit and its qualifier
//   clear                : synchronous counter clear (wins over a coincident increment)
//   match                : one-cycle pulse per detected pattern
//   count, count_sat     : match count and its sticky saturation flag
//   state                : FSM state for debug (IDLE=0, FILL=1, RUN=2)
// Optional feature macro: SEQDET_MASK_EN adds the cfg_mask port and masked compare.
module seq_pattern_counter
  import seq_pkg::*;
#(
  parameter  int PAT_MAX = PAT_MAX_DEF,
  parameter  int CNT_W   = CNT_W_DEF,
  localparam int LEN_W   = $clog2(PAT_MAX + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PAT_MAX-1:0] cfg_pattern,
`ifdef SEQDET_MASK_EN
  input  logic [PAT_MAX-1:0] cfg_mask,
`endif
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               bit_valid,
  input  logic               bit_in,
  input  logic               clear,
  output logic               match,
  output logic [CNT_W-1:0]   count,
  output logic               count_sat,
  output logic [1:0]         state
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_MAX);

  state_t             state_q;
  logic [PAT_MAX-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [PAT_MAX-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic               match_q;
  logic               rdy_q;

  logic [PAT_MAX-1:0] hist_new;
  logic [LEN_W-1:0]   fill_new;
  logic [PAT_MAX-1:0] len_mask;
  logic [PAT_MAX-1:0] care_mask;
  logic [LEN_W-1:0]   len_clamped;
  logic               cfg_load;
  logic               compare_now;
  logic               hit;

  // rdy_q holds last cycle's ~en. Every state goes to IDLE exactly when en was low,
  // so rdy_q also means "state is IDLE"; gating with the live en keeps a config
  // from landing in the same cycle the detector is being started.
  assign cfg_ready = rdy_q & ~en;
  assign cfg_load  = cfg_valid & cfg_ready;

  assign hist_new = {hist_q[PAT_MAX-2:0], bit_in};
  assign fill_new = fill_q + LEN_W'(1);

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0) begin
      len_clamped = LEN_W'(1);
    end else if (cfg_len > LEN_MAX) begin
      len_clamped = LEN_MAX;
    end
  end

`ifdef SEQDET_MASK_EN
  logic [PAT_MAX-1:0] mask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
    end else if (cfg_load) begin
      mask_q <= cfg_mask;
    end
  end

  assign care_mask = ~mask_q;
`else
  assign care_mask = '1;
`endif

  // A compare happens on every accepted bit in RUN, and in FILL only on the
  // bit that completes len bits of history.
  assign compare_now = en && bit_valid &&
                       ((state_q == ST_RUN) || ((state_q == ST_FILL) && (fill_new == len_q)));
  assign hit = compare_now && (((hist_new ^ pattern_q) & len_mask & care_mask) == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pattern_q <= '0;
      len_q     <= LEN_MAX;
      overlap_q <= 1'b1;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      match_q <= hit;
      rdy_q   <= ~en;
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_q <= ST_FILL;
            hist_q  <= '0;
            fill_q  <= '0;
          end else if (cfg_load) begin
            pattern_q <= cfg_pattern;
            len_q     <= len_clamped;
            overlap_q <= cfg_overlap;
          end
        end
        ST_FILL: begin
          if (!en) begin
            state_q <= ST_IDLE;
          end else if (bit_valid) begin
            if (hit && !overlap_q) begin
              // Restart: the next match needs len fresh bits.
              hist_q <= '0;
              fill_q <= '0;
            end else begin
              hist_q <= hist_new;
              fill_q <= fill_new;
              if (fill_new == len_q) begin
                state_q <= ST_RUN;
              end
            end
          end
        end
        ST_RUN: begin
          if (!en) begin
            state_q <= ST_IDLE;
          end else if (bit_valid) begin
            if (hit && !overlap_q) begin
              state_q <= ST_FILL;
              hist_q  <= '0;
              fill_q  <= '0;
            end else begin
              hist_q <= hist_new;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit),
    .clear (clear),
    .count (count),
    .sat   (count_sat)
  );

  assign match = match_q;
  assign state = state_q;

endmodule

// File: tb/tb_seq_pattern_counter.sv
// tb_seq_pattern_counter: table-driven bench with an expectation queue for seq_pattern_counter.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_pattern_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        cfg_valid;
  logic [15:0] cfg_pattern;
  logic [4:0]  cfg_len;
  logic        cfg_overlap;
  logic        bit_valid;
  logic        bit_in;
  logic        clear;
`ifdef SEQDET_MASK_EN
  logic [15:0] cfg_mask = '0;
`endif

  logic        cfg_ready, match, count_sat;
  logic [7:0]  count;
  logic [1:0]  state;
  logic        cfg_ready_s, match_s, count_sat_s;
  logic [1:0]  count_s;
  logic [1:0]  state_s;

  always #5 clk = ~clk;

  seq_pattern_counter #(.PAT_MAX(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern),
`ifdef SEQDET_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .bit_valid(bit_valid), .bit_in(bit_in),
    .clear(clear), .match(match), .count(count), .count_sat(count_sat), .state(state)
  );

  // Narrow-counter instance sharing all inputs, used for the saturation scenario.
  seq_pattern_counter #(.PAT_MAX(16), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_s),
    .cfg_pattern(cfg_pattern),
`ifdef SEQDET_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .bit_valid(bit_valid), .bit_in(bit_in),
    .clear(clear), .match(match_s), .count(count_s), .count_sat(count_sat_s), .state(state_s)
  );

  typedef struct packed {
    logic       en;
    logic       bv;
    logic       b;
    logic       clr;
    logic       m;
    logic [7:0] c;
    logic [1:0] s;
  } vec_t;

  typedef struct packed {
    logic       m;
    logic [7:0] c;
    logic [1:0] s;
  } exp_t;

  vec_t tab[$];
  exp_t sb[$];
  int   seg[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic en_, input logic bv_, input logic b_, input logic clr_,
                              input logic m_, input int c_, input int s_);
    vec_t v;
    v.en = en_; v.bv = bv_; v.b = b_; v.clr = clr_;
    v.m = m_; v.c = 8'(c_); v.s = 2'(s_);
    tab.push_back(v);
  endfunction

  task automatic run_seg(input int k, input string name);
    for (int i = seg[k]; i < seg[k+1]; i++) begin
      vec_t v;
      exp_t e;
      v = tab[i];
      en = v.en; bit_valid = v.bv; bit_in = v.b; clear = v.clr;
      e.m = v.m; e.c = v.c; e.s = v.s;
      sb.push_back(e);
      tick();
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s[%0d]: scoreboard empty", name, i - seg[k]);
      end else begin
        e = sb.pop_front();
        check($sformatf("%s[%0d].match", name, i - seg[k]), match, e.m);
        check($sformatf("%s[%0d].count", name, i - seg[k]), count, e.c);
        check($sformatf("%s[%0d].state", name, i - seg[k]), state, e.s);
      end
    end
    bit_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clear = 1'b0;
    tick();
    reset = 1'b0;
    check("rst.state", state, 0);
    check("rst.match", match, 0);
    check("rst.count", count, 0);
    check("rst.count_sat", count_sat, 0);
    check("rst.cfg_ready", cfg_ready, 0);
    check("rst.count_small", count_s, 0);
    tick();
    check("idle.cfg_ready", cfg_ready, 1);
    check("idle.cfg_ready_small", cfg_ready_s, 1);
  endtask

  task automatic load(input logic [15:0] pat, input logic [4:0] len, input logic ov);
    en = 1'b0; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cfg_valid = 1'b1;
    #1;
    check("load.cfg_ready", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b1;
    // en bv b clr | match count state
    seg.push_back(tab.size());  // 0: overlap, pattern 1011
    add(1,0,0,0, 0,0,1);
    add(1,1,1,0, 0,0,1); add(1,1,0,0, 0,0,1); add(1,1,1,0, 0,0,1); add(1,1,1,0, 1,1,2);
    add(1,1,0,0, 0,1,2); add(1,0,1,0, 0,1,2); add(1,1,1,0, 0,1,2); add(1,1,1,0, 1,2,2);
    add(1,1,0,0, 0,2,2); add(1,1,1,0, 0,2,2);
    seg.push_back(tab.size());  // 1: non-overlap, pattern 1011
    add(1,0,0,0, 0,0,1);
    add(1,1,1,0, 0,0,1); add(1,1,0,0, 0,0,1); add(1,1,1,0, 0,0,1); add(1,1,1,0, 1,1,1);
    add(1,1,0,0, 0,1,1); add(1,1,1,0, 0,1,1); add(1,1,1,0, 0,1,1); add(0,0,0,0, 0,1,0);
    seg.push_back(tab.size());  // 2: disable mid-fill
    add(1,0,0,0, 0,1,1); add(1,1,1,0, 0,1,1); add(1,1,0,0, 0,1,1); add(0,0,0,0, 0,1,0);
    seg.push_back(tab.size());  // 3: after gated config attempt
    add(1,1,1,0, 0,1,1); add(1,1,1,0, 0,1,1); add(0,0,0,0, 0,1,0);
    add(1,0,0,0, 0,1,1); add(1,1,1,0, 0,1,1); add(1,1,0,0, 0,1,1); add(1,1,1,0, 0,1,1);
    add(1,1,1,0, 1,2,2); add(0,0,0,0, 0,2,0);
    seg.push_back(tab.size());  // 4: cfg_len 0 loads as 1, pattern 1
    add(1,0,0,0, 0,2,1); add(1,1,1,0, 1,3,2); add(1,1,0,0, 0,3,2); add(1,1,1,0, 1,4,2);
    add(0,0,0,0, 0,4,0);
    seg.push_back(tab.size());  // 5: saturation stream, pattern 11
    add(1,0,0,0, 0,0,1); add(1,1,1,0, 0,0,1); add(1,1,1,0, 1,1,2); add(1,1,1,0, 1,2,2);
    add(1,1,1,0, 1,3,2); add(1,1,1,0, 1,4,2); add(1,1,1,0, 1,5,2);
    seg.push_back(tab.size());  // 6: clear coinciding with a match
    add(1,1,1,1, 1,0,2);
    seg.push_back(tab.size());  // 7: count resumes, plain clear, disable
    add(1,1,1,0, 1,1,2); add(1,0,0,1, 0,0,2); add(0,0,0,0, 0,0,0);
`ifdef SEQDET_MASK_EN
    seg.push_back(tab.size());  // 8: masked compare, pattern 1001 mask 0100
    add(1,0,0,0, 0,0,1);
    add(1,1,1,0, 0,0,1); add(1,1,1,0, 0,0,1); add(1,1,0,0, 0,0,1); add(1,1,1,0, 1,1,1);
    add(1,1,1,0, 0,1,1); add(1,1,0,0, 0,1,1); add(1,1,0,0, 0,1,1); add(1,1,1,0, 1,2,1);
    add(1,1,0,0, 0,2,1); add(1,1,0,0, 0,2,1); add(1,1,0,0, 0,2,1); add(1,1,1,0, 0,2,2);
    add(0,0,0,0, 0,2,0);
`endif
    seg.push_back(tab.size());

    do_reset();
    load(16'h000B, 5'd4, 1'b1);
    run_seg(0, "overlap");

    // Reset on the bit that would complete 1011 must suppress the match.
    en = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; en = 1'b0; bit_valid = 1'b0;
    check("midrst.match", match, 0);
    check("midrst.count", count, 0);
    check("midrst.state", state, 0);
    tick();
    check("midrst.cfg_ready", cfg_ready, 1);

    load(16'h000B, 5'd4, 1'b0);
    run_seg(1, "nonoverlap");

    load(16'h000B, 5'd4, 1'b1);
    run_seg(2, "midfill");

    // Config offered while en is high must be refused.
    en = 1'b1; cfg_valid = 1'b1; cfg_pattern = 16'h0000; cfg_len = 5'd4;
    #1;
    check("gate.cfg_ready", cfg_ready, 0);
    tick();
    cfg_valid = 1'b0;
    check("gate.state", state, 1);
    run_seg(3, "gated");

    load(16'h0001, 5'd0, 1'b1);
    run_seg(4, "len0");

    do_reset();
    load(16'h0003, 5'd2, 1'b1);
    run_seg(5, "sat");
    check("sat.count_small", count_s, 3);
    check("sat.sat_small", count_sat_s, 1);
    check("sat.match_small", match_s, 1);
    check("sat.state_small", state_s, 2);
    check("sat.count_sat_wide", count_sat, 0);
    run_seg(6, "clrhit");
    check("clrhit.count_small", count_s, 0);
    check("clrhit.sat_small", count_sat_s, 0);
    run_seg(7, "tail");

`ifdef SEQDET_MASK_EN
    do_reset();
    cfg_mask = 16'h0004;
    load(16'h0009, 5'd4, 1'b0);
    run_seg(8, "mask");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
